// File: rtl/counter_pkg.sv
// counter_pkg: shared definitions for the LED counter run controller.
// Holds the FSM state encoding, the run-mode encoding, the default
// counter width and a small state-classification helper.
package counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2,
        FINISH   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_UP    = 2'd0,
        MODE_DOWN  = 2'd1,
        MODE_PP    = 2'd2,
        MODE_SWEEP = 2'd3
    } mode_e;

    // True for the two states in which the counter is being driven.
    function automatic logic is_run(state_e s);
        return (s == RUN_UP) || (s == RUN_DOWN);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides the clock into a registered one-cycle tick.
// While running, an internal count walks 0..TICK_DIV-1 and the tick is
// high exactly in the cycle where the count equals TICK_DIV-1.
// Ports:
//   CLK   in  clock, rising edge
//   RST   in  synchronous active-high reset
//   clear in  force count to 0 and suppress the tick next cycle
//   run   in  advance the count (ignored while clear is high)
//   tick  out registered one-cycle tick, period TICK_DIV
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // The tick is registered off the next count, so it lines up with the
    // cycle in which the registered count sits at LAST.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
            tick_d = (cnt_d == LAST);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: run controller for the LED up/down counter.
// Issues DIR and a periodic CNT_EN tick, watches the counter value and
// implements continuous up, continuous down, ping-pong and single sweep.
// Ports:
//   CLK    in  clock, rising edge
//   RST    in  synchronous active-high reset
//   START  in  strobe, begins a run in MODE (ignored while busy)
//   STOP   in  strobe, aborts a run (wins over START)
//   MODE   in  00 up, 01 down, 10 ping-pong, 11 single sweep up
//   LED_IN in  current counter value
//   DIR    out 1 = count up, 0 = count down (registered)
//   CNT_EN out one-cycle count enable (registered)
//   BUSY   out high in RUN_UP / RUN_DOWN
//   DONE   out one-cycle pulse when a sweep completes
module counter_sequencer
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned TICK_DIV = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             STOP,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] LED_IN,
    output logic             DIR,
    output logic             CNT_EN,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    state_e state_q, state_d;
    mode_e  mode_q, mode_d;
    logic   dir_q, dir_d;
    logic   at_max, at_min;
    logic   ps_clear, ps_run;

    // Limits are only acted on between ticks, so a value seen in the same
    // cycle as a tick never triggers a second decision on stale data.
    assign at_max = (LED_IN == MAX_VAL) && !CNT_EN;
    assign at_min = (LED_IN == '0) && !CNT_EN;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        unique case (state_q)
            IDLE: begin
                if (START && !STOP) begin
                    mode_d  = mode_e'(MODE);
                    state_d = (mode_e'(MODE) == MODE_DOWN) ? RUN_DOWN : RUN_UP;
                end
            end
            RUN_UP: begin
                if (STOP) begin
                    state_d = IDLE;
                end else if (at_max) begin
                    if (mode_q == MODE_PP) begin
                        state_d = RUN_DOWN;
                    end else if (mode_q == MODE_SWEEP) begin
                        state_d = FINISH;
                    end
                end
            end
            RUN_DOWN: begin
                if (STOP) begin
                    state_d = IDLE;
                end else if (at_min && mode_q == MODE_PP) begin
                    state_d = RUN_UP;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == RUN_UP) begin
            dir_d = 1'b1;
        end else if (state_d == RUN_DOWN) begin
            dir_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            mode_q  <= MODE_UP;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
        end
    end

    // Prescaler restarts on every run start and is held cleared whenever the
    // next state is not a run state; a reversal keeps its phase.
    assign ps_clear = (state_q == IDLE) || !is_run(state_d);
    assign ps_run   = is_run(state_q);

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .CLK  (CLK),
        .RST  (RST),
        .clear(ps_clear),
        .run  (ps_run),
        .tick (CNT_EN)
    );

    assign DIR  = dir_q;
    assign BUSY = is_run(state_q);
    assign DONE = (state_q == FINISH);

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [2:0] led;
  logic       dir, cnt_en, busy, done;
  logic       load_en = 1'b0;
  logic [2:0] load_val = 3'd0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(3), .TICK_DIV(4)) dut (
    .CLK   (clk),
    .RST   (rst),
    .START (start),
    .STOP  (stop),
    .MODE  (mode),
    .LED_IN(led),
    .DIR   (dir),
    .CNT_EN(cnt_en),
    .BUSY  (busy),
    .DONE  (done)
  );

  always @(posedge clk) begin
    if (load_en)     led <= load_val;
    else if (cnt_en) led <= dir ? led + 3'd1 : led - 3'd1;
  end

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load(input logic [2:0] v);
    load_en = 1'b1; load_val = v;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [1:0] m);
    start = 1'b1; mode = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(1, 0));
      mode  = 2'($urandom_range(3, 0));
      checks++;
      if ({dir, cnt_en, busy, done} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: {dir,cnt_en,busy,done}=%b expected 0000", i, {dir, cnt_en, busy, done});
      end
    end
    start = 1'b0; rst = 1'b0;
    load(3'd0);
    pulse_start(2'b00);
    checks++;
    if ({busy, dir, cnt_en} !== 3'b110) begin
      errors++;
      $display("FAIL start_up_n1: {busy,dir,cnt_en}=%b expected 110", {busy, dir, cnt_en});
    end
    for (int unsigned t = 2; t <= 16; t++) begin
      @(negedge clk);
      checks++;
      if (cnt_en !== ((t % 4) == 0)) begin
        errors++;
        $display("FAIL tick_phase t=%0d: cnt_en=%b expected %b", t, cnt_en, ((t % 4) == 0));
      end
    end
    checks++;
    if (led !== 3'd3) begin
      errors++;
      $display("FAIL up_count: led=%0d expected 3", led);
    end
  endtask

  task automatic test_pingpong();
    logic [2:0] exp_seq [15] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6,
                                 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
    logic [2:0] prev;
    logic       prev_dir;
    int n = 0, seen7 = -1, fall = -1;
    do_reset();
    load(3'd0);
    pulse_start(2'b10);
    prev = led; prev_dir = dir;
    for (int unsigned t = 1; t < 200 && n < 15; t++) begin
      if (led !== prev) begin
        checks++;
        if (led !== exp_seq[n]) begin
          errors++;
          $display("FAIL pingpong_seq step %0d: led=%0d expected %0d", n, led, exp_seq[n]);
        end
        n++;
        prev = led;
      end
      if (led == 3'd7 && seen7 < 0) seen7 = t;
      if (prev_dir && !dir && fall < 0) fall = t;
      prev_dir = dir;
      @(negedge clk);
    end
    checks++;
    if (n != 15) begin
      errors++;
      $display("FAIL pingpong_steps: got %0d steps expected 15", n);
    end
    checks++;
    if (fall - seen7 != 1) begin
      errors++;
      $display("FAIL pingpong_dir_fall: dir fell %0d cycles after led=7 expected 1", fall - seen7);
    end
  endtask

  task automatic run_sweep(input logic [2:0] from, input int exp_ticks, input int exp_done_t);
    int ticks = 0, dones = 0, done_t = -1;
    do_reset();
    load(from);
    pulse_start(2'b11);
    for (int unsigned t = 1; t <= 30; t++) begin
      if (cnt_en) ticks++;
      if (done) begin
        dones++;
        if (done_t < 0) done_t = t;
        checks++;
        if (busy !== 1'b0 || cnt_en !== 1'b0) begin
          errors++;
          $display("FAIL sweep_finish_outputs: busy=%b cnt_en=%b expected 0 0", busy, cnt_en);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (ticks != exp_ticks) begin
      errors++;
      $display("FAIL sweep_ticks from %0d: ticks=%0d expected %0d", from, ticks, exp_ticks);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL sweep_done_count from %0d: got %0d expected 1", from, dones);
    end
    checks++;
    if (done_t != exp_done_t) begin
      errors++;
      $display("FAIL sweep_done_time from %0d: t=%0d expected %0d", from, done_t, exp_done_t);
    end
    checks++;
    if (led !== 3'd7 || busy !== 1'b0) begin
      errors++;
      $display("FAIL sweep_end: led=%0d busy=%b expected 7 0", led, busy);
    end
  endtask

  task automatic test_sweep();
    run_sweep(3'd5, 2, 10);
    run_sweep(3'd7, 0, 2);
  endtask

  task automatic test_stop();
    int ticks = 0, extra = 0;
    logic [2:0] v;
    do_reset();
    load(3'd2);
    pulse_start(2'b01);
    for (int unsigned t = 0; t < 40 && ticks < 3; t++) begin
      if (cnt_en) ticks++;
      @(negedge clk);
    end
    checks++;
    if (ticks != 3 || led !== 3'd7) begin
      errors++;
      $display("FAIL stop_prerun: ticks=%0d led=%0d expected 3 7", ticks, led);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if ({busy, cnt_en, dir, done} !== 4'b0000) begin
      errors++;
      $display("FAIL stop_outputs: {busy,cnt_en,dir,done}=%b expected 0000", {busy, cnt_en, dir, done});
    end
    for (int unsigned t = 0; t < 12; t++) begin
      if (cnt_en || busy || done) extra++;
      @(negedge clk);
    end
    checks++;
    if (extra != 0 || led !== 3'd7) begin
      errors++;
      $display("FAIL stop_quiet: activity=%0d led=%0d expected 0 7", extra, led);
    end

    pulse_start(2'b00);
    for (int unsigned t = 0; t < 20 && !cnt_en; t++) @(negedge clk);
    v = led;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if (led !== 3'(v + 3'd1) || busy !== 1'b0 || cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL stop_on_tick: led=%0d busy=%b cnt_en=%b expected %0d 0 0", led, busy, cnt_en, 3'(v + 3'd1));
    end

    start = 1'b1; stop = 1'b1; mode = 2'b01;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    extra = 0;
    for (int unsigned t = 0; t < 8; t++) begin
      if (busy || cnt_en) extra++;
      @(negedge clk);
    end
    checks++;
    if (extra != 0 || dir !== 1'b1) begin
      errors++;
      $display("FAIL start_stop_idle: activity=%0d dir=%b expected 0 1", extra, dir);
    end
  endtask

  task automatic test_start_busy();
    logic [2:0] exp_seq [3] = '{3'd6, 3'd7, 3'd0};
    logic [2:0] prev;
    int n = 0, dir_bad = 0;
    do_reset();
    load(3'd5);
    pulse_start(2'b00);
    @(negedge clk);
    pulse_start(2'b10);
    prev = led;
    for (int unsigned t = 0; t < 40 && n < 3; t++) begin
      if (led !== prev) begin
        checks++;
        if (led !== exp_seq[n]) begin
          errors++;
          $display("FAIL busy_start_seq step %0d: led=%0d expected %0d", n, led, exp_seq[n]);
        end
        n++;
        prev = led;
      end
      if (dir !== 1'b1) dir_bad++;
      @(negedge clk);
    end
    checks++;
    if (n != 3 || dir_bad != 0) begin
      errors++;
      $display("FAIL busy_start_run: steps=%0d dir_low=%0d expected 3 0", n, dir_bad);
    end
  endtask

  task automatic test_rst_midrun();
    int t = 1;
    do_reset();
    load(3'd0);
    pulse_start(2'b10);
    for (int unsigned i = 0; i < 40 && led !== 3'd4; i++) @(negedge clk);
    checks++;
    if (led !== 3'd4) begin
      errors++;
      $display("FAIL rst_mid_reach: led=%0d expected 4", led);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({dir, cnt_en, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_outputs: {dir,cnt_en,busy,done}=%b expected 0000", {dir, cnt_en, busy, done});
    end
    pulse_start(2'b00);
    while (t < 20 && !cnt_en) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t != 4) begin
      errors++;
      $display("FAIL rst_mid_first_tick: first tick at t=%0d expected 4", t);
    end
  endtask

  initial begin
    test_reset();
    test_pingpong();
    test_sweep();
    test_stop();
    test_start_busy();
    test_rst_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
